// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Round-robin arbiter that shares one 32-bit memory port between two
//   requesters: requester 0 (instruction fetch) and requester 1 (load/store).
//   Each granted access occupies the port for LAT cycles (BUSY). A one-cycle
//   done strobe goes back to the granted requester (DONE), and the read data
//   captured in the last BUSY cycle is returned on rdata.
//
// Parameters
//   LAT        memory access cycles per transaction, legal range 1..15
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous reset, active-high
//   req0/1     access request from requester 0 / 1
//   addr0/1    access address from requester 0 / 1
//   wdata0/1   write data from requester 0 / 1
//   we0/1      write enable from requester 0 / 1
//   mem_rdata  read data from memory, valid in the last BUSY cycle
//   sel        granted requester, drives the S input of the port muxes
//   mem_addr   shared port address   (sel ? addr1  : addr0)
//   mem_wdata  shared port write data (sel ? wdata1 : wdata0)
//   mem_en     shared port enable, high in every BUSY cycle
//   mem_we     shared port write enable, gated by mem_en
//   rdata      registered read data of the most recently completed access
//   done0/1    one-cycle completion strobe to requester 0 / 1
//   busy       high whenever an access is being sequenced or completed
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    input  logic        we0,
    input  logic        req1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    input  logic        we1,
    input  logic [31:0] mem_rdata,
    output logic        sel,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] rdata,
    output logic        done0,
    output logic        done1,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // BUSY counts down from LAT-1 to 0, so it lasts exactly LAT cycles.
    localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

    state_e      state_q;
    logic        sel_q;
    logic        last_q;
    logic [3:0]  cnt_q;
    logic [31:0] rdata_q;
    logic        done0_q;
    logic        done1_q;

    logic        grant_valid_d;
    logic        grant_d;

    // Arbitration decision, only consumed in IDLE. On contention the
    // requester that was not served last wins; otherwise the lone requester.
    // NOTE: every combinational output gets a value on every path, so no latch is inferred.
    always_comb begin
        grant_valid_d = req0 | req1;
        if (req0 && req1) begin
            grant_d = ~last_q;
        end else begin
            grant_d = req1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // Reset wins over an access in flight; no done strobe is issued.
            // last starts at 1 so the first contended grant goes to requester 0.
            state_q <= ST_IDLE;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
        end else begin
            // Strobes are single-cycle: cleared unless set below.
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_valid_d) begin
                        sel_q   <= grant_d;
                        last_q  <= grant_d;
                        cnt_q   <= CNT_LOAD;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // sel stays frozen for the whole access; a dropped
                    // request does not abort it.
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        rdata_q <= mem_rdata;
                        if (sel_q) begin
                            done1_q <= 1'b1;
                        end else begin
                            done0_q <= 1'b1;
                        end
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // No arbitration here: caps throughput at one access
                    // per LAT+2 cycles and lets requesters drop req.
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign sel       = sel_q;
    assign mem_addr  = sel_q ? addr1 : addr0;
    assign mem_wdata = sel_q ? wdata1 : wdata0;
    assign mem_en    = (state_q == ST_BUSY);
    // Gated with mem_en so no write can reach memory in IDLE or DONE.
    assign mem_we    = (sel_q ? we1 : we0) & mem_en;
    assign rdata     = rdata_q;
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. Four instances with LAT = 1..4 share
//   one set of inputs; each scenario resets all of them and then observes the
//   instance whose latency it targets. Cycle n is the interval after the n-th
//   rising edge following reset release; inputs are driven and outputs sampled
//   1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        req0;
    logic [31:0] addr0;
    logic [31:0] wdata0;
    logic        we0;
    logic        req1;
    logic [31:0] addr1;
    logic [31:0] wdata1;
    logic        we1;
    logic [31:0] mem_rdata;

    logic        sel       [4];
    logic [31:0] mem_addr  [4];
    logic [31:0] mem_wdata [4];
    logic        mem_en    [4];
    logic        mem_we    [4];
    logic [31:0] rdata     [4];
    logic        done0     [4];
    logic        done1     [4];
    logic        busy      [4];

    int checks;
    int failures;
    int pulses;

    // Instance index g has LAT = g + 1.
    for (genvar g = 0; g < 4; g++) begin : g_dut
        mem_port_arbiter #(.LAT(g + 1)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .req0      (req0),
            .addr0     (addr0),
            .wdata0    (wdata0),
            .we0       (we0),
            .req1      (req1),
            .addr1     (addr1),
            .wdata1    (wdata1),
            .we1       (we1),
            .mem_rdata (mem_rdata),
            .sel       (sel[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_en    (mem_en[g]),
            .mem_we    (mem_we[g]),
            .rdata     (rdata[g]),
            .done0     (done0[g]),
            .done1     (done1[g]),
            .busy      (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves every instance in IDLE at cycle 0 with all inputs quiet.
    task automatic do_reset();
        rst       = 1'b1;
        req0      = 1'b0;
        addr0     = 32'd0;
        wdata0    = 32'd0;
        we0       = 1'b0;
        req1      = 1'b0;
        addr1     = 32'd0;
        wdata1    = 32'd0;
        we1       = 1'b0;
        mem_rdata = 32'd0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        pulses   = 0;

        // ---------------- reset state, all latencies ----------------
        do_reset();
        for (int g = 0; g < 4; g++) begin
            check("rst_busy",  32'(busy[g]),   32'd0);
            check("rst_sel",   32'(sel[g]),    32'd0);
            check("rst_en",    32'(mem_en[g]), 32'd0);
            check("rst_rdata", rdata[g],       32'd0);
            check("rst_done",  32'({done0[g], done1[g]}), 32'd0);
        end

        // ---------------- T1: LAT=1 single fetch ----------------
        req0      = 1'b1;
        addr0     = 32'h0000_0100;
        mem_rdata = 32'hDEAD_BEEF;
        tick();                                         // cycle 1: BUSY
        check("t1_sel",   32'(sel[0]),    32'd0);
        check("t1_en",    32'(mem_en[0]), 32'd1);
        check("t1_addr",  mem_addr[0],    32'h0000_0100);
        check("t1_done0", 32'(done0[0]),  32'd0);
        tick();                                         // cycle 2: DONE
        check("t1_done0_c2", 32'(done0[0]),  32'd1);
        check("t1_en_c2",    32'(mem_en[0]), 32'd0);
        check("t1_rdata",    rdata[0],       32'hDEAD_BEEF);
        req0      = 1'b0;
        mem_rdata = 32'h0BAD_F00D;
        tick();                                         // cycle 3: IDLE
        check("t1_done0_c3", 32'(done0[0]), 32'd0);
        check("t1_busy_c3",  32'(busy[0]),  32'd0);
        check("t1_rdata_hold", rdata[0],    32'hDEAD_BEEF);

        // ---------------- T2: LAT=3 write from requester 1 ----------------
        do_reset();
        req1   = 1'b1;
        we1    = 1'b1;
        addr1  = 32'h0000_2000;
        wdata1 = 32'hA5A5_A5A5;
        check("t2_we_idle", 32'(mem_we[2]), 32'd0);
        for (int c = 1; c <= 5; c++) begin
            tick();
            check("t2_we",    32'(mem_we[2]), (c <= 3) ? 32'd1 : 32'd0);
            check("t2_done1", 32'(done1[2]),  (c == 4) ? 32'd1 : 32'd0);
            check("t2_done0", 32'(done0[2]),  32'd0);
            if (c <= 3) begin
                check("t2_wdata", mem_wdata[2], 32'hA5A5_A5A5);
                check("t2_addr",  mem_addr[2],  32'h0000_2000);
            end
            if (c == 4) begin
                req1 = 1'b0;
                we1  = 1'b0;
            end
        end

        // ---------------- T3: LAT=1 continuous contention ----------------
        do_reset();
        req0  = 1'b1;
        req1  = 1'b1;
        addr0 = 32'h0000_0010;
        addr1 = 32'h0000_0020;
        for (int c = 1; c <= 12; c++) begin
            tick();
            check("t3_done0", 32'(done0[0]), (c == 2 || c == 8)  ? 32'd1 : 32'd0);
            check("t3_done1", 32'(done1[0]), (c == 5 || c == 11) ? 32'd1 : 32'd0);
            if (c == 1 || c == 7) begin
                check("t3_sel0",  32'(sel[0]), 32'd0);
                check("t3_addr0", mem_addr[0], 32'h0000_0010);
            end
            if (c == 4 || c == 10) begin
                check("t3_sel1",  32'(sel[0]), 32'd1);
                check("t3_addr1", mem_addr[0], 32'h0000_0020);
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;

        // ---------------- T4: LAT=4 reset during BUSY ----------------
        do_reset();
        req0      = 1'b1;
        mem_rdata = 32'h1234_5678;
        for (int c = 1; c <= 5; c++) begin
            tick();
            check("t4_pre_done0", 32'(done0[3]), (c == 5) ? 32'd1 : 32'd0);
            if (c == 5) req0 = 1'b0;
        end
        check("t4_pre_rdata", rdata[3], 32'h1234_5678);
        tick();                                         // IDLE
        req0 = 1'b1;                                    // pulse
        tick();                                         // BUSY cycle 1
        req0 = 1'b0;
        check("t4_busy1", 32'(busy[3]), 32'd1);
        tick();                                         // BUSY cycle 2
        check("t4_busy2", 32'(mem_en[3]), 32'd1);
        rst = 1'b1;
        tick();                                         // aborted
        rst = 1'b0;
        check("t4_abort_busy",  32'(busy[3]),   32'd0);
        check("t4_abort_en",    32'(mem_en[3]), 32'd0);
        check("t4_abort_sel",   32'(sel[3]),    32'd0);
        check("t4_abort_rdata", rdata[3],       32'd0);
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            if (done0[3] || done1[3]) pulses++;
            tick();
        end
        check("t4_no_done", 32'(pulses), 32'd0);

        // ---------------- T5: LAT=2 request dropped during BUSY ----------------
        do_reset();
        req0 = 1'b1;
        tick();                                         // BUSY cycle 1
        req0 = 1'b0;
        check("t5_busy", 32'(mem_en[1]), 32'd1);
        pulses = 0;
        for (int c = 2; c <= 7; c++) begin
            tick();
            if (done0[1]) pulses++;
            if (c == 3) check("t5_done0_c3", 32'(done0[1]), 32'd1);
        end
        check("t5_pulse_count", 32'(pulses),   32'd1);
        check("t5_idle_after",  32'(busy[1]),  32'd0);
        check("t5_no_done1",    32'(done1[1]), 32'd0);

        // ---------------- T6: LAT=2 req1 first, then both ----------------
        do_reset();
        req1 = 1'b1;
        tick();                                         // cycle 1: BUSY for 1
        check("t6_sel_first", 32'(sel[1]), 32'd1);
        req0 = 1'b1;
        tick();                                         // cycle 2
        tick();                                         // cycle 3: DONE
        check("t6_done1", 32'(done1[1]), 32'd1);
        check("t6_done0", 32'(done0[1]), 32'd0);
        tick();                                         // cycle 4: IDLE, both high
        check("t6_idle", 32'(busy[1]), 32'd0);
        tick();                                         // cycle 5: BUSY for 0
        check("t6_sel_second", 32'(sel[1]),    32'd0);
        check("t6_en_second",  32'(mem_en[1]), 32'd1);
        req0 = 1'b0;
        req1 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
